credit_allocator_rr: RTL

Parametrised credit-based switch allocator for the credit_based router: maps per-input one-hot routing requests onto PORTS output ports. It arbitrates each output round-robin and locks an output to its winning input until a tail flit passes (wormhole). It tracks downstream buffer credits per output with a configurable depth. It sits between the input FIFOs/LBDR routing logic and the crossbar, and replaces the fixed 5-port, 3-credit, no-lock allocator.

---
 rtl/credit_allocator_rr.sv | 129 ++++++++++++
 1 files changed

// File: rtl/credit_allocator_rr.sv
// Round-robin wormhole switch allocator with per-output downstream credit counters.
// Latency: grant is combinational, zero cycles after req. Backpressure: an output stalls at zero credits or while locked to an empty owner.
module credit_allocator_rr #(
  parameter int  PORTS        = 5,
  parameter int  CREDIT_DEPTH = 4,
  localparam int CW           = $clog2(CREDIT_DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [PORTS-1:0]         credit_in,
  input  logic [PORTS*PORTS-1:0]   req,
  input  logic [PORTS-1:0]         empty,
  input  logic [PORTS-1:0]         tail,
  output logic [PORTS*PORTS-1:0]   grant,
  output logic [PORTS-1:0]         valid,
  output logic [PORTS*CW-1:0]      credit_cnt,
  output logic                     credit_err
);
  localparam int            PW   = (PORTS > 1) ? $clog2(PORTS) : 1;
  localparam logic [CW-1:0] CMAX = CW'(CREDIT_DEPTH);

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e                   state_q [PORTS];
  state_e                   state_d [PORTS];
  logic [PORTS-1:0][PW-1:0] owner_q, owner_d;
  logic [PORTS-1:0][PW-1:0] last_q, last_d;
  logic [PORTS-1:0][CW-1:0] cnt_q, cnt_d;
  logic                     err_q, err_d;

  // sel[i][o]: one-hot output chosen by input i; elig/gnt are indexed [o][i]
  logic [PORTS-1:0][PORTS-1:0] sel, elig, gnt;

  always_comb begin
    sel  = '0;
    elig = '0;
    for (int i = 0; i < PORTS; i++) begin
      sel[i] = req[i*PORTS +: PORTS] & (-req[i*PORTS +: PORTS]);
    end
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        elig[o][i] = sel[i][o] & ~empty[i];
      end
    end
  end

  always_comb begin : arb
    logic hit;
    int   idx;
    hit = 1'b0;
    idx = 0;
    gnt = '0;
    for (int o = 0; o < PORTS; o++) begin
      state_d[o] = state_q[o];
      owner_d[o] = owner_q[o];
      last_d[o]  = last_q[o];
      hit        = 1'b0;
      if (cnt_q[o] != '0) begin
        if (state_q[o] == IDLE) begin
          for (int k = 1; k <= PORTS; k++) begin
            idx = int'(last_q[o]) + k;
            if (idx >= PORTS) idx = idx - PORTS;
            if (!hit && elig[o][idx]) begin
              hit          = 1'b1;
              gnt[o][idx]  = 1'b1;
              last_d[o]    = PW'(idx);
              if (!tail[idx]) begin
                state_d[o] = LOCKED;
                owner_d[o] = PW'(idx);
              end
            end
          end
        end else if (!empty[owner_q[o]]) begin
          // the owner's req is not re-examined while the packet is in flight
          gnt[o][owner_q[o]] = 1'b1;
          if (tail[owner_q[o]]) state_d[o] = IDLE;
        end
      end
      if (reset) gnt[o] = '0;
    end
  end

  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    for (int o = 0; o < PORTS; o++) begin
      if (credit_in[o] && !(|gnt[o])) begin
        if (cnt_q[o] < CMAX) cnt_d[o] = cnt_q[o] + CW'(1);
        else                 err_d    = 1'b1;
      end else if (!credit_in[o] && (|gnt[o])) begin
        cnt_d[o] = cnt_q[o] - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= IDLE;
        owner_q[o] <= '0;
        last_q[o]  <= PW'(PORTS - 1);
        cnt_q[o]   <= CMAX;
      end
      err_q <= 1'b0;
    end else begin
      for (int o = 0; o < PORTS; o++) begin
        state_q[o] <= state_d[o];
      end
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    grant      = '0;
    valid      = '0;
    credit_cnt = '0;
    for (int o = 0; o < PORTS; o++) begin
      grant[o*PORTS +: PORTS] = gnt[o];
      valid[o]                = |gnt[o];
      credit_cnt[o*CW +: CW]  = cnt_q[o];
    end
  end

  assign credit_err = err_q;

endmodule
